// File: rtl/img_pkg.sv
// ----------------------------------------------------------------------------
// img_pkg : shared types and constants for the frame controller (rev 1.0)
// ----------------------------------------------------------------------------
`default_nettype none

package img_pkg;

  localparam int               PIX_W   = 8;
  localparam logic [PIX_W-1:0] PIX_MAX = 8'd255;

  typedef enum logic [1:0] {
    OP_BRIGHT_UP = 2'd0,
    OP_BRIGHT_DN = 2'd1,
    OP_BINARISE  = 2'd2,
    OP_INVERT    = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/img_pix_op.sv
// ----------------------------------------------------------------------------
// img_pix_op : combinational per-pixel operator with clip flag (rev 1.0)
// ----------------------------------------------------------------------------
`default_nettype none

module img_pix_op
  import img_pkg::*;
(
  input  op_e              op,
  input  logic [PIX_W-1:0] pix,
  input  logic [PIX_W-1:0] value,
  input  logic [PIX_W-1:0] threshold,
  output logic [PIX_W-1:0] result,
  output logic             sat
);

  logic [PIX_W:0] w_sum;
  logic [PIX_W:0] w_diff;

  assign w_sum  = {1'b0, pix} + {1'b0, value};
  assign w_diff = {1'b0, pix} - {1'b0, value};

  // sat only reports clipping of the brighten/darken operators
  always_comb begin
    result = '0;
    sat    = 1'b0;
    case (op)
      OP_BRIGHT_UP: begin
        sat    = w_sum[PIX_W];
        result = w_sum[PIX_W] ? PIX_MAX : w_sum[PIX_W-1:0];
      end
      OP_BRIGHT_DN: begin
        sat    = w_diff[PIX_W];
        result = w_diff[PIX_W] ? '0 : w_diff[PIX_W-1:0];
      end
      OP_BINARISE: result = (pix >= threshold) ? PIX_MAX : '0;
      default:     result = PIX_MAX - pix;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/img_frame_ctrl.sv
// ----------------------------------------------------------------------------
// img_frame_ctrl : start/busy/done frame sequencer, credit-limited 2-deep
// result FIFO. Macro IMG_CTRL_STATS_EN enables the saturation counter. (rev 1.0)
// ----------------------------------------------------------------------------
`default_nettype none

module img_frame_ctrl
  import img_pkg::*;
#(
  parameter int NPIX = 98304,
  parameter int AW   = 17
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [1:0]       cfg_select,
  input  logic [PIX_W-1:0] cfg_value,
  input  logic [PIX_W-1:0] cfg_threshold,
  output logic             busy,
  output logic             done,
  output logic             rd_en,
  output logic [AW-1:0]    rd_addr,
  input  logic [PIX_W-1:0] rd_data,
  output logic             wr_en,
  output logic [AW-1:0]    wr_addr,
  output logic [PIX_W-1:0] wr_data,
  input  logic             wr_ready,
  output logic [AW:0]      sat_count
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(NPIX - 1);

  state_e           r_state;
  state_e           w_next;
  op_e              r_op;
  logic [PIX_W-1:0] r_value;
  logic [PIX_W-1:0] r_thr;
  logic [AW-1:0]    r_rd_addr;
  logic [AW-1:0]    r_pend_addr;
  logic             r_inflight;
  logic             r_done;
  logic [PIX_W-1:0] r_fifo_data [2];
  logic [AW-1:0]    r_fifo_addr [2];
  logic [1:0]       r_count;

  logic             w_accept;
  logic             w_abort;
  logic             w_pop;
  logic             w_push;
  logic             w_slot;
  logic             w_credit;
  logic             w_last_rd;
  logic             w_last_wr;
  logic [2:0]       w_occ;
  logic [PIX_W-1:0] w_result;
  logic             w_sat;

  img_pix_op u_pix_op (
    .op        (r_op),
    .pix       (rd_data),
    .value     (r_value),
    .threshold (r_thr),
    .result    (w_result),
    .sat       (w_sat)
  );

  assign wr_en   = (r_count != 2'd0);
  assign wr_addr = r_fifo_addr[0];
  assign wr_data = r_fifo_data[0];
  assign rd_addr = r_rd_addr;
  assign done    = r_done;

  assign w_accept  = (r_state == ST_IDLE) && start && !abort;
  assign w_abort   = abort && (r_state != ST_IDLE);
  assign w_pop     = wr_en && wr_ready;
  assign w_push    = r_inflight;
  // occupancy the FIFO will see once the outstanding read lands
  assign w_occ     = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_credit  = (w_occ < 3'd2);
  assign w_slot    = ((r_count - {1'b0, w_pop}) != 2'd0);
  assign w_last_rd = rd_en && (r_rd_addr == LAST_ADDR);
  assign w_last_wr = w_pop && (wr_addr == LAST_ADDR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept) w_next = ST_RUN;
      ST_RUN:   if (abort) w_next = ST_IDLE; else if (w_last_rd) w_next = ST_DRAIN;
      ST_DRAIN: if (abort || w_last_wr) w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    busy  = (r_state != ST_IDLE);
    rd_en = (r_state == ST_RUN) && w_credit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op           <= OP_BRIGHT_UP;
      r_value        <= '0;
      r_thr          <= '0;
      r_rd_addr      <= '0;
      r_pend_addr    <= '0;
      r_inflight     <= 1'b0;
      r_done         <= 1'b0;
      r_count        <= 2'd0;
      r_fifo_data[0] <= '0;
      r_fifo_data[1] <= '0;
      r_fifo_addr[0] <= '0;
      r_fifo_addr[1] <= '0;
    end else begin
      r_done <= (r_state == ST_DRAIN) && w_last_wr && !abort;
      if (w_accept) begin
        r_op      <= op_e'(cfg_select);
        r_value   <= cfg_value;
        r_thr     <= cfg_threshold;
        r_rd_addr <= '0;
      end else if (rd_en && !w_last_rd) begin
        r_rd_addr <= r_rd_addr + AW'(1);
      end
      if (rd_en) r_pend_addr <= r_rd_addr;
      if (w_abort) begin
        r_inflight <= 1'b0;
        r_count    <= 2'd0;
      end else begin
        r_inflight <= rd_en;
        if (w_pop) begin
          r_fifo_data[0] <= r_fifo_data[1];
          r_fifo_addr[0] <= r_fifo_addr[1];
        end
        if (w_push) begin
          r_fifo_data[w_slot] <= w_result;
          r_fifo_addr[w_slot] <= r_pend_addr;
        end
        r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
      end
    end
  end

`ifdef IMG_CTRL_STATS_EN
  logic [AW:0] r_sat_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          r_sat_count <= '0;
    else if (w_accept)                   r_sat_count <= '0;
    else if (w_push && w_sat && !w_abort) r_sat_count <= r_sat_count + (AW+1)'(1);
  end

  assign sat_count = r_sat_count;
`else
  logic w_unused_sat;
  assign w_unused_sat = w_sat;
  assign sat_count    = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_img_frame_ctrl.sv
// ----------------------------------------------------------------------------
// tb_img_frame_ctrl : scoreboard bench for img_frame_ctrl (rev 1.0)
// ----------------------------------------------------------------------------
`default_nettype none

module tb_img_frame_ctrl;
  import img_pkg::*;

  localparam int NPIX = 8;
  localparam int AW   = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [1:0]    cfg_select = 2'd0;
  logic [7:0]    cfg_value = 8'd0;
  logic [7:0]    cfg_threshold = 8'd0;
  logic          busy, done, rd_en, wr_en;
  logic          wr_ready = 1'b1;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [7:0]    rd_data = 8'd0;
  logic [7:0]    wr_data;
  logic [AW:0]   sat_count;

  int checks = 0;
  int failures = 0;
  bit rand_ready = 1'b0;
  bit prev_stall = 1'b0;
  int prev_a, prev_d;

  logic [7:0] mem [NPIX];

  typedef struct {
    int addr;
    int data;
  } wr_t;
  wr_t exp_q[$];

  img_frame_ctrl #(.NPIX(NPIX), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .cfg_select(cfg_select), .cfg_value(cfg_value), .cfg_threshold(cfg_threshold),
    .busy(busy), .done(done), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .sat_count(sat_count)
  );

  always #5 clk = ~clk;

  // synchronous source memory, one cycle of read latency
  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  initial forever begin
    @(posedge clk);
    #1;
    wr_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic int ref_pix(input int sel, input int v, input int t, input int d);
    case (sel)
      0:       return (d + v > 255) ? 255 : d + v;
      1:       return (d < v) ? 0 : d - v;
      2:       return (d >= t) ? 255 : 0;
      default: return 255 - d;
    endcase
  endfunction

  function automatic int load_expect(input int sel, input int v, input int t);
    int sat = 0;
    for (int a = 0; a < NPIX; a++) begin
      exp_q.push_back('{addr: a, data: ref_pix(sel, v, t, int'(mem[a]))});
      if ((sel == 0 && int'(mem[a]) + v > 255) || (sel == 1 && int'(mem[a]) < v)) sat++;
    end
    return sat;
  endfunction

  // monitor: pops the scoreboard on every accepted write
  always @(negedge clk) begin
    if (rst_n) begin
      if (prev_stall) begin
        check("hold_wr_en", wr_en, 1);
        check("hold_wr_addr", wr_addr, prev_a);
        check("hold_wr_data", wr_data, prev_d);
      end
      if (wr_en && wr_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_write actual_addr=%0d actual_data=%0d required=none", wr_addr, wr_data);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          check("wr_addr", wr_addr, e.addr);
          check("wr_data", wr_data, e.data);
        end
      end
      prev_stall = wr_en && !wr_ready;
      prev_a     = int'(wr_addr);
      prev_d     = int'(wr_data);
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic start_frame(input int sel, input int v, input int t);
    @(posedge clk);
    #1;
    cfg_select    = 2'(sel);
    cfg_value     = 8'(v);
    cfg_threshold = 8'(t);
    start         = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input int sel, input int v, input int t, input bit hold_start,
                           output int done_n);
    int sat_model;
    int exp_sat;
    sat_model = load_expect(sel, v, t);
`ifdef IMG_CTRL_STATS_EN
    exp_sat = sat_model;
`else
    exp_sat = 0;
`endif
    start_frame(sel, v, t);
    if (!hold_start) start = 1'b0;
    cfg_select    = ~cfg_select;
    cfg_value     = cfg_value ^ 8'h5a;
    cfg_threshold = ~cfg_threshold;
    done_n = 0;
    for (int n = 1; n <= 400 && done_n == 0; n++) begin
      @(negedge clk);
      if (n == 1) begin
        check("first_rd_en", rd_en, 1);
        check("first_rd_addr", rd_addr, 0);
        check("busy_from_e1", busy, 1);
      end
      if (n == 2) check("no_wr_en_e2", wr_en, 0);
      if (n == 3) check("first_wr_en_e3", wr_en, 1);
      if (n == 6) start = 1'b0;
      if (done) begin
        done_n = n;
        check("busy_low_at_done", busy, 0);
      end
    end
    start = 1'b0;
    if (done_n == 0) begin
      checks++;
      failures++;
      $display("FAIL done_timeout actual=none required=done_pulse");
    end
    check("queue_drained", exp_q.size(), 0);
    check("sat_count", sat_count, exp_sat);
    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("sat_count_hold", sat_count, exp_sat);
  endtask

  initial begin
    int dn;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rd_en", rd_en, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_rd_addr", rd_addr, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_sat_count", sat_count, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // brighten with clipping, start held high mid-frame, cfg scrambled mid-frame
    mem = '{8'd0, 8'd100, 8'd195, 8'd196, 8'd255, 8'd200, 8'd10, 8'd1};
    run_frame(0, 60, 0, 1'b1, dn);
    check("done_cycle_op0", dn, NPIX + 3);

    mem = '{8'd59, 8'd60, 8'd61, 8'd0, 8'd255, 8'd128, 8'd61, 8'd7};
    run_frame(1, 60, 0, 1'b0, dn);
    check("done_cycle_op1", dn, NPIX + 3);
    mem = '{8'd159, 8'd160, 8'd0, 8'd255, 8'd161, 8'd1, 8'd158, 8'd200};
    run_frame(2, 0, 160, 1'b0, dn);
    mem = '{8'd0, 8'd37, 8'd255, 8'd128, 8'd1, 8'd254, 8'd77, 8'd99};
    run_frame(3, 0, 0, 1'b0, dn);

    // start together with abort in IDLE: nothing starts
    @(posedge clk);
    #1 start = 1'b1;
    abort = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    check("abort_wins_busy", busy, 0);
    check("abort_wins_rd_en", rd_en, 0);

    // abort during the 4th write
    void'(load_expect(0, 10, 0));
    start_frame(0, 10, 0);
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("abort_rd_en", rd_en, 0);
      check("abort_wr_en", wr_en, 0);
      check("abort_done", done, 0);
      check("abort_busy", busy, 0);
    end
    check("abort_writes_sent", NPIX - exp_q.size(), 4);
    exp_q.delete();
    run_frame(3, 0, 0, 1'b0, dn);

    // asynchronous reset in the middle of a frame
    void'(load_expect(0, 1, 0));
    start_frame(0, 1, 0);
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_rd_en", rd_en, 0);
    check("arst_wr_en", wr_en, 0);
    check("arst_rd_addr", rd_addr, 0);
    check("arst_wr_addr", wr_addr, 0);
    check("arst_wr_data", wr_data, 0);
    check("arst_sat_count", sat_count, 0);
    exp_q.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    run_frame(2, 0, 100, 1'b0, dn);

    // random backpressure over 64 pixels
    rand_ready = 1'b1;
    for (int f = 0; f < 8; f++) begin
      for (int a = 0; a < NPIX; a++) mem[a] = 8'($urandom_range(0, 255));
      run_frame(int'($urandom_range(0, 3)), int'($urandom_range(0, 255)),
                int'($urandom_range(0, 255)), 1'b0, dn);
    end
    rand_ready = 1'b0;
    repeat (3) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
